// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: processes a DBW-bit operation SW bits per clock,
// LSB slice first, holding the inter-slice carry in a register.
module addsub_seq #(
  parameter int DBW = 32,
  parameter int SW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op,
  input  logic           ci,
  input  logic [DBW-1:0] a,
  input  logic [DBW-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DBW-1:0] o,
  output logic           co,
  output logic           v,
  output logic           z,
  output logic           n
);

  localparam int NS = DBW / SW;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  if ((SW < 1) || ((DBW % SW) != 0)) begin : g_bad_sw
    $error("addsub_seq: DBW must be a non-zero multiple of SW");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DBW-1:0]  a_q, a_d;
  logic [DBW-1:0]  b_q, b_d;
  logic            carry_q, carry_d;
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic [DBW-1:0]  acc_q, acc_d;
  logic [DBW-1:0]  o_q, o_d;
  logic            co_q, co_d;
  logic            v_q, v_d;
  logic            z_q, z_d;
  logic            n_q, n_d;
  logic [SW:0]     sum;
  logic [DBW+SW-1:0] acc_ins;

  // Operands shift right one slice per RUN cycle, so the active slice is always
  // at the bottom; the result fills in from the top and lands aligned after NS slices.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    acc_d   = acc_q;
    o_d     = o_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    sum     = {1'b0, a_q[SW-1:0]} + {1'b0, b_q[SW-1:0]} + {{SW{1'b0}}, carry_q};
    acc_ins = {sum[SW-1:0], acc_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = op ? ~b : b;
          carry_d = ci;
          a_msb_d = a[DBW-1];
          b_msb_d = op ? ~b[DBW-1] : b[DBW-1];
        end
      end
      RUN: begin
        acc_d   = acc_ins[DBW+SW-1:SW];
        a_d     = a_q >> SW;
        b_d     = b_q >> SW;
        carry_d = sum[SW];
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          o_d     = acc_d;
          co_d    = sum[SW];
          z_d     = (acc_d == '0);
          n_d     = acc_d[DBW-1];
          v_d     = (a_msb_q == b_msb_q) && (acc_d[DBW-1] != a_msb_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers: cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  // Working datapath registers: only meaningful after an accept
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    carry_q <= carry_d;
    a_msb_q <= a_msb_d;
    b_msb_q <= b_msb_d;
    acc_q   <= acc_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign o         = o_q;
  assign co        = co_q;
  assign v         = v_q;
  assign z         = z_q;
  assign n         = n_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: three instances (SW=8, SW=32, SW=1) share stimulus,
// each gated by its own in_valid; expected values are hand-computed constants.
module tb_addsub_seq;

  logic        clk;
  logic        rst_n;
  logic        op;
  logic        ci;
  logic        out_ready;
  logic [2:0]  in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  in_ready_w, ov_w, co_w, v_w, z_w, n_w;
  logic [31:0] o_w [3];

  int nvec;
  int nmis;

  addsub_seq #(.DBW(32), .SW(8)) u_sw8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .op(op), .ci(ci), .a(a), .b(b), .out_valid(ov_w[0]), .out_ready(out_ready),
    .o(o_w[0]), .co(co_w[0]), .v(v_w[0]), .z(z_w[0]), .n(n_w[0]));

  addsub_seq #(.DBW(32), .SW(32)) u_sw32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .op(op), .ci(ci), .a(a), .b(b), .out_valid(ov_w[1]), .out_ready(out_ready),
    .o(o_w[1]), .co(co_w[1]), .v(v_w[1]), .z(z_w[1]), .n(n_w[1]));

  addsub_seq #(.DBW(32), .SW(1)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .op(op), .ci(ci), .a(a), .b(b), .out_valid(ov_w[2]), .out_ready(out_ready),
    .o(o_w[2]), .co(co_w[2]), .v(v_w[2]), .z(z_w[2]), .n(n_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one operation, measure latency to out_valid and check the result flags.
  // Leaves the instance in DONE; the caller completes the handshake.
  task automatic run_op(input int idx, input string tag, input logic op_v, input logic ci_v,
                        input logic [31:0] a_v, input logic [31:0] b_v, input logic [31:0] o_e,
                        input logic co_e, input logic v_e, input logic z_e, input logic n_e,
                        input int lat_e);
    int lat;
    chk({tag, ".rdy"}, {31'b0, in_ready_w[idx]}, 32'd1);
    a = a_v;
    b = b_v;
    op = op_v;
    ci = ci_v;
    in_valid[idx] = 1'b1;
    tick();
    in_valid[idx] = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h5A5A_A5A5;
    op = ~op_v;
    ci = ~ci_v;
    lat = 0;
    while (!ov_w[idx] && lat < 200) begin
      chk({tag, ".busy"}, {31'b0, in_ready_w[idx]}, 32'd0);
      tick();
      lat++;
    end
    chk({tag, ".lat"}, lat, lat_e);
    chk({tag, ".o"}, o_w[idx], o_e);
    chk({tag, ".co"}, {31'b0, co_w[idx]}, {31'b0, co_e});
    chk({tag, ".v"}, {31'b0, v_w[idx]}, {31'b0, v_e});
    chk({tag, ".z"}, {31'b0, z_w[idx]}, {31'b0, z_e});
    chk({tag, ".n"}, {31'b0, n_w[idx]}, {31'b0, n_e});
  endtask

  task automatic finish_hs(input int idx, input string tag);
    out_ready = 1'b1;
    chk({tag, ".rdy_in_done"}, {31'b0, in_ready_w[idx]}, 32'd0);
    tick();
    chk({tag, ".ov_drop"}, {31'b0, ov_w[idx]}, 32'd0);
    chk({tag, ".rdy_back"}, {31'b0, in_ready_w[idx]}, 32'd1);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst_n = 1'b0;
    in_valid = 3'b000;
    out_ready = 1'b1;
    op = 1'b0;
    ci = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk("rst.ov", {29'b0, ov_w}, 32'd0);
    chk("rst.rdy", {29'b0, in_ready_w}, 32'd7);
    chk("rst.o", o_w[0], 32'd0);
    chk("rst.flags", {28'b0, co_w[0], v_w[0], z_w[0], n_w[0]}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1..T4 on SW=8
    run_op(0, "t1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 4);
    finish_hs(0, "t1");
    run_op(0, "t2", 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0, 0, 4);
    finish_hs(0, "t2");
    chk("t2.hold_o", o_w[0], 32'h7FFF_FFFF);
    run_op(0, "t3a", 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 1, 4);
    finish_hs(0, "t3a");
    run_op(0, "t3b", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 1, 0, 1, 4);
    finish_hs(0, "t3b");
    run_op(0, "t4a", 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 0, 0, 0, 0, 4);
    finish_hs(0, "t4a");
    run_op(0, "t4b", 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1, 0, 0, 0, 4);
    finish_hs(0, "t4b");

    // T5 backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    run_op(0, "t5", 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 0, 0, 0, 4);
    for (int i = 0; i < 5; i++) begin
      a = 32'h0000_0000 + i;
      b = 32'hFFFF_0000;
      in_valid[0] = 1'b1;
      tick();
      chk("t5.stall_o", o_w[0], 32'h2345_6789);
      chk("t5.stall_ov", {31'b0, ov_w[0]}, 32'd1);
      chk("t5.stall_rdy", {31'b0, in_ready_w[0]}, 32'd0);
    end
    in_valid[0] = 1'b0;
    finish_hs(0, "t5");
    tick();
    chk("t5.no_accept", {31'b0, in_ready_w[0]}, 32'd1);
    chk("t5.kept_o", o_w[0], 32'h2345_6789);

    // T6 reset during RUN slice 2 aborts the operation
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    op = 1'b0;
    ci = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6.ov", {31'b0, ov_w[0]}, 32'd0);
    chk("t6.rdy", {31'b0, in_ready_w[0]}, 32'd1);
    chk("t6.o", o_w[0], 32'd0);
    chk("t6.flags", {28'b0, co_w[0], v_w[0], z_w[0], n_w[0]}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6.no_emit", {31'b0, ov_w[0]}, 32'd0);
    end
    run_op(0, "t6.t1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 4);
    finish_hs(0, "t6.t1");

    // SW=DBW and SW=1 variants
    run_op(1, "w32.t1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 1);
    finish_hs(1, "w32.t1");
    run_op(1, "w32.t2", 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0, 0, 1);
    finish_hs(1, "w32.t2");
    run_op(2, "w1.t1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 32);
    finish_hs(2, "w1.t1");
    run_op(2, "w1.t2", 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0, 0, 32);
    finish_hs(2, "w1.t2");
    run_op(2, "w1.t3", 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 1, 32);
    finish_hs(2, "w1.t3");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
